// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the button-triggered UART transmitter
package uart_pkg;

  // Frame sequencer states; PARITY is skipped when no parity bit is configured
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Parity selection codes for the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Whole clk cycles per serial bit; the remainder of the division is dropped
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter emitting a one-clk tick every CLKS_PER_BIT cycles
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1; clear restarts the period so a new frame's start bit is full length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Tick marks the last cycle of a bit period, so the FSM advances on the wrap edge
  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_trigger.sv
// rtl/uart_tx_trigger.sv - one frame per button press UART transmitter with re-arm guard
module uart_tx_trigger
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t               state;
  logic                 armed;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_reg;
  logic                 tick;
  logic                 accept;
  logic                 parity_calc;

  // A request is taken only when idle and the button has been released since the last frame
  assign accept = (state == ST_IDLE) && start && armed;

  // Parity over the payload being latched, inverted for odd parity
  assign parity_calc = (PARITY == PAR_ODD) ? ~(^data_in) : (^data_in);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      armed      <= 1'b1;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!start) begin
        armed <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift_reg  <= data_in;
            parity_reg <= parity_calc;
            armed      <= 1'b0;
            bit_cnt    <= '0;
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY != PAR_NONE) begin
                tx    <= parity_reg;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx      <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_trigger.sv
// tb/tb_uart_tx_trigger.sv - directed self-checking bench for uart_tx_trigger
module tb_uart_tx_trigger;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  logic [7:0] data_in;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;

  int n_checks = 0;
  int n_fail   = 0;

  bit cap_tx   [0:511];
  bit cap_busy [0:511];
  bit cap_done [0:511];

  always #5 clk = ~clk;

  // u0: 8N1, u1: 8E1, u2: 8O1, u3: 7N2
  uart_tx_trigger #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .data_in(data_in),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_trigger #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .data_in(data_in),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_trigger #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .data_in(data_in),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx_trigger #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .data_in(data_in[6:0]),
    .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample c is taken 1 ns after edge c, where edge 0 is the accept edge
  task automatic capture(input int sel, input int n, input int hold, input int poke,
                         input logic [7:0] poke_data, input bit rearm, input logic [7:0] next_data);
    for (int c = 0; c < n; c++) begin
      step();
      cap_tx[c]   = tx_v[sel];
      cap_busy[c] = busy_v[sel];
      cap_done[c] = done_v[sel];
      if (c + 1 == hold) start_v[sel] = 1'b0;
      if (poke >= 0 && c == poke) begin
        start_v[sel] = 1'b1;
        data_in      = poke_data;
      end
      if (poke >= 0 && c == poke + 1) start_v[sel] = 1'b0;
      if (rearm && c == n - 1) begin
        start_v[sel] = 1'b1;
        data_in      = next_data;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({tx_v[i], busy_v[i], done_v[i]} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_hold dut=%0d {tx,busy,done} got %b expected 100", i, {tx_v[i], busy_v[i], done_v[i]});
      end
    end
    rst = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({tx_v[i], busy_v[i], done_v[i]} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_release dut=%0d {tx,busy,done} got %b expected 100", i, {tx_v[i], busy_v[i], done_v[i]});
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp;
    exp = 16'b1101001010;
    data_in = 8'hA5;
    start_v[0] = 1'b1;
    capture(0, 176, 1, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 176; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 160) ? exp[c/16] : 1'b1, c < 160, c == 160};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic_frame c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
  endtask

  task automatic test_long_pulse();
    logic [15:0] exp;
    exp = 16'b1001111000;
    step();
    data_in = 8'h3C;
    start_v[0] = 1'b1;
    capture(0, 180, 6, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 180; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 160) ? exp[c/16] : 1'b1, c < 160, c == 160};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pulse6 c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
    start_v[0] = 1'b1;
    capture(0, 200, 1000, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 200; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 160) ? exp[c/16] : 1'b1, c < 160, c == 160};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pulse200 c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
    start_v[0] = 1'b0;
    step();
    start_v[0] = 1'b1;
    capture(0, 176, 1, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 176; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 160) ? exp[c/16] : 1'b1, c < 160, c == 160};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rearm_frame c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
  endtask

  task automatic test_parity();
    logic [15:0] exp_even;
    logic [15:0] exp_odd;
    exp_even = 16'b11000001110;
    exp_odd  = 16'b10000001110;
    step();
    data_in = 8'h07;
    start_v[1] = 1'b1;
    capture(1, 192, 1, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 192; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 176) ? exp_even[c/16] : 1'b1, c < 176, c == 176};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL parity_even c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
    start_v[2] = 1'b1;
    capture(2, 192, 1, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 192; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 176) ? exp_odd[c/16] : 1'b1, c < 176, c == 176};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL parity_odd c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
  endtask

  task automatic test_busy_reject();
    logic [15:0] exp;
    exp = 16'b1101001010;
    step();
    data_in = 8'hA5;
    start_v[0] = 1'b1;
    capture(0, 190, 1, 50, 8'h3C, 1'b0, 8'h00);
    for (int c = 0; c < 190; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 160) ? exp[c/16] : 1'b1, c < 160, c == 160};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL busy_reject c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    exp_a = 16'b1101001010;
    exp_b = 16'b1001111000;
    step();
    data_in = 8'hA5;
    start_v[0] = 1'b1;
    capture(0, 161, 1, -1, 8'h00, 1'b1, 8'h3C);
    for (int c = 0; c < 161; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 160) ? exp_a[c/16] : 1'b1, c < 160, c == 160};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL b2b_first c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
    capture(0, 176, 1, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 176; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 160) ? exp_b[c/16] : 1'b1, c < 160, c == 160};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL b2b_second c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] exp_ff;
    logic [15:0] exp_00;
    exp_ff = 16'b1111111110;
    exp_00 = 16'b1000000000;
    step();
    data_in = 8'h00;
    start_v[0] = 1'b1;
    capture(0, 5, 1, -1, 8'h00, 1'b0, 8'h00);
    n_checks++;
    if (cap_tx[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_bit_low got %b expected 0", cap_tx[4]);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({tx_v[0], busy_v[0], done_v[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL async_reset_startbit {tx,busy,done} got %b expected 100", {tx_v[0], busy_v[0], done_v[0]});
    end
    step();
    rst = 1'b1;
    step();
    data_in = 8'hFF;
    start_v[0] = 1'b1;
    capture(0, 70, 1, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 70; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {exp_ff[c/16], 1'b1, 1'b0};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL ff_partial c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({tx_v[0], busy_v[0], done_v[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL async_reset_mid {tx,busy,done} got %b expected 100", {tx_v[0], busy_v[0], done_v[0]});
    end
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < 120; c++) begin
      step();
      n_checks++;
      if ({tx_v[0], busy_v[0], done_v[0]} !== 3'b100) begin
        n_fail++;
        $display("FAIL post_reset_idle c=%0d {tx,busy,done} got %b expected 100", c, {tx_v[0], busy_v[0], done_v[0]});
      end
    end
    data_in = 8'h00;
    start_v[0] = 1'b1;
    capture(0, 176, 1, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 176; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 160) ? exp_00[c/16] : 1'b1, c < 160, c == 160};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL after_reset_frame c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
  endtask

  task automatic test_stop2_data7();
    logic [15:0] exp;
    exp = 16'b1110101010;
    step();
    data_in = 8'h55;
    start_v[3] = 1'b1;
    capture(3, 176, 1, -1, 8'h00, 1'b0, 8'h00);
    for (int c = 0; c < 176; c++) begin
      logic [2:0] want;
      logic [2:0] got;
      want = {(c < 160) ? exp[c/16] : 1'b1, c < 160, c == 160};
      got  = {cap_tx[c], cap_busy[c], cap_done[c]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stop2_data7 c=%0d {tx,busy,done} got %b expected %b", c, got, want);
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    start_v = 4'b0000;
    data_in = 8'h00;
    test_reset();
    test_basic_frame();
    test_long_pulse();
    test_parity();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_frame();
    test_stop2_data7();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_trigger.md
Name: uart_tx_trigger

Overview:
- Button-triggered UART transmitter, one stage downstream of the push-button one-shot pulse generator.
- The one-shot drives `start` with a short pulse, up to 6 clk wide. On that pulse the block latches `data_in` and serialises one 8N1-style frame on `tx`, LSB first.
- Re-arm logic guarantees exactly one frame per button press, whatever the pulse width.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. The derived local constant CLKS_PER_BIT = CLK_FREQ/BAUD (integer division) must be >= 2.
- DATA_BITS, 8, payload bits per frame, legal range 5..8.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  transmit request from the one-shot; level, any width >= 1 clk.
- data_in  in  DATA_BITS  payload; sampled only on the accept cycle.
- tx  out  1  serial line; idle high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-clk pulse at the end of each frame.

Behaviour:
- Reset values (rst=0, asynchronous): tx=1, busy=0, done=0, state=IDLE, armed=1, bit and baud counters=0, shift register=0.
- States: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
- Accept:
  - Happens in IDLE on the clk edge where start=1 and armed=1.
  - At that edge: data_in is latched into the shift register, armed clears, state goes to START, busy=1, and tx=0 from that edge.
  - Latency: tx falls on the same edge at which start is sampled high.
- Re-arm: armed sets on any edge where start=0. A start that stays high through the end of a frame does not begin a second frame.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1. Each bit period is exactly CLKS_PER_BIT clk cycles.
  - The state or bit advance occurs on the wrap edge.
- DATA: tx = shift_reg[0], shifted right each bit period; the bit index runs 0..DATA_BITS-1.
- PARITY:
  - tx = XOR of the latched payload for even parity, inverted for odd.
  - Parity is computed at accept and held in a register.
- STOP: tx=1 for STOP_BITS x CLKS_PER_BIT cycles.
- Frame end:
  - On the final wrap edge of STOP: state goes to IDLE, busy goes to 0, and done=1 for exactly one cycle.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) x CLKS_PER_BIT cycles.
- Back-to-back frames:
  - Start may be accepted on the edge immediately after done, provided armed=1.
  - A start that arrives while busy (armed or not) is ignored. It is not queued.
- Changing data_in during a frame has no effect.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The partial frame is abandoned and no done pulse is issued. After rst is released, the next start is accepted normally.
- Outputs tx, busy and done are registered, with no combinational path from any input.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity code constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - a constant function clks_per_bit(clk_freq, baud).
- Sub-module uart_baud_tick: a counter with a clear input that emits a one-clk tick every CLKS_PER_BIT cycles. The FSM clears it on accept.
- Everything else (FSM, shift register, re-arm flag) lives in the top block.

Test Plan:
- All scenarios use CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16.
- Basic frame: PARITY=0, STOP_BITS=1, data_in=0xA5, 1-clk start -> tx = 0, 1,0,1,0,0,1,0,1, 1, each bit held 16 clk; busy high for 160 clk; done pulses once at clk 160 after accept.
- Long one-shot pulse: start held 6 clk, then held 200 clk, data_in=0x3C -> exactly one frame in each case; after the 200-clk hold, a second frame starts only after start has gone low and high again.
- Parity: PARITY=1, data_in=0x07 -> parity bit 1 at bit slot 9; PARITY=2 with the same data -> 0; frame length 176 clk.
- Busy rejection and back-to-back: pulse start at clk 50 of a frame with a different data_in -> frame unchanged, nothing queued; pulse start on the cycle after done -> the new frame's start bit begins that edge.
- Reset mid-frame: assert rst at clk 70 of a 0xFF frame -> tx=1 and busy=0 immediately, no done pulse; release rst, start with 0x00 -> clean full frame.
- STOP_BITS=2, DATA_BITS=7: data_in=0x55 -> tx high for 32 clk after the 7 data bits; done at clk 160.
